demux_stripe_1xn: RTL



---
 rtl/demux_pkg.sv | 18 +
 rtl/demux_out_stage.sv | 55 +++++
 rtl/demux_stripe_1xn.sv | 114 +++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and helpers for the 1xN lane de-striping demux.
//   W_DEF / LANES_DEF : default word width and lane count
//   ptr_w()           : width of the lane pointer for a given lane count
//   lane_lo()         : low bit index of lane i inside a packed LANES*W word
package demux_pkg;

    localparam int W_DEF     = 8;
    localparam int LANES_DEF = 4;

    function automatic int ptr_w(input int lanes);
        return (lanes < 2) ? 1 : $clog2(lanes);
    endfunction

    function automatic int lane_lo(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/demux_out_stage.sv
// demux_out_stage: output group register with valid/ready hold.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   load               : capture load_data/load_valid this edge
//   load_data/valid    : group to present (LANES*W data, LANES valid bits)
//   out_ready          : downstream consumes the presented group
//   out_data/out_valid : presented group
//   load_ok            : register is empty or draining this cycle
module demux_out_stage #(
    parameter int W     = 8,
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [LANES*W-1:0] load_data,
    input  logic [LANES-1:0]   load_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_data,
    output logic [LANES-1:0]   out_valid,
    output logic               load_ok
);

    logic [LANES*W-1:0] data_q, data_d;
    logic [LANES-1:0]   valid_q, valid_d;
    logic               out_full;

    always_comb begin
        out_full = |valid_q;
        load_ok  = !out_full | out_ready;
        data_d   = data_q;
        valid_d  = valid_q;
        // A load in the same cycle as a drain simply replaces the group.
        if (load) begin
            data_d  = load_data;
            valid_d = load_valid;
        end else if (out_full & out_ready) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/demux_stripe_1xn.sv
// demux_stripe_1xn: 1-to-LANES round-robin de-striping demux.
// Consecutive accepted W-bit words fill lanes 0..LANES-1; each completed
// group is presented as one LANES*W word with per-lane valid bits.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   in_data/in_valid    : input word stream, in_ready back-pressure
//   flush               : close the current partial group (DEMUX_FLUSH_EN only)
//   out_data/out_valid  : presented group, lane i at bits [i*W +: W]
//   out_ready           : downstream consumes the presented group
// Macro DEMUX_FLUSH_EN: adds the flush port and partial-group emission.
module demux_stripe_1xn
    import demux_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LANES = LANES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [W-1:0]       in_data,
    input  logic               in_valid,
    output logic               in_ready,
`ifdef DEMUX_FLUSH_EN
    input  logic               flush,
`endif
    output logic [LANES*W-1:0] out_data,
    output logic [LANES-1:0]   out_valid,
    input  logic               out_ready
);

    localparam int PW = ptr_w(LANES);
    localparam logic [PW-1:0] LAST = PW'(LANES - 1);

    // Gather buffer only needs LANES-1 slots: the last lane's word goes
    // straight into the output register on the transfer edge.
    logic [LANES-2:0][W-1:0] slot_q, slot_d;
    logic [LANES-2:0]        mask_q, mask_d;
    logic [PW-1:0]           ptr_q, ptr_d;

    logic               flush_w, last_lane, accept, xfer, load_ok;
    logic [LANES*W-1:0] grp_data;
    logic [LANES-1:0]   grp_valid;

`ifdef DEMUX_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    always_comb begin
        last_lane = (ptr_q == LAST);
        in_ready  = load_ok | (!last_lane & !flush_w);
        accept    = in_valid & in_ready;
        xfer      = load_ok & ((accept & last_lane) |
                               (flush_w & ((ptr_q != '0) | accept)));

        // Group as it would be emitted this cycle; unfilled lanes are zero.
        grp_data  = '0;
        grp_valid = '0;
        for (int i = 0; i < LANES - 1; i++) begin
            if (mask_q[i]) begin
                grp_data[lane_lo(i, W) +: W] = slot_q[i];
                grp_valid[i]                 = 1'b1;
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (accept && ptr_q == PW'(i)) begin
                grp_data[lane_lo(i, W) +: W] = in_data;
                grp_valid[i]                 = 1'b1;
            end
        end

        slot_d = slot_q;
        mask_d = mask_q;
        ptr_d  = ptr_q;
        if (xfer) begin
            mask_d = '0;
            ptr_d  = '0;
        end else if (accept) begin
            // Without a transfer ptr is below LAST, so no wrap is needed.
            for (int i = 0; i < LANES - 1; i++) begin
                if (ptr_q == PW'(i)) begin
                    slot_d[i] = in_data;
                    mask_d[i] = 1'b1;
                end
            end
            ptr_d = ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q <= '0;
            mask_q <= '0;
            ptr_q  <= '0;
        end else begin
            slot_q <= slot_d;
            mask_q <= mask_d;
            ptr_q  <= ptr_d;
        end
    end

    demux_out_stage #(.W(W), .LANES(LANES)) u_out (
        .clk        (clk),
        .reset      (reset),
        .load       (xfer),
        .load_data  (grp_data),
        .load_valid (grp_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .load_ok    (load_ok)
    );

endmodule
